// File: rtl/arith_mult_cst_mersenne_arb_pkg.sv
// Shared helpers for the Mersenne-constant multiplier arbiter.
// Optional build macro used by the top: ARITH_MULT_CST_MERSENNE_ARB_PERF_CNT_EN
package arith_mult_cst_mersenne_arb_pkg;

  localparam int PERF_CNT_W = 32;

  // Cycles from multiplier input to multiplier output valid
  function automatic int mult_lat(input int in_pipe);
    return in_pipe + 1;
  endfunction

  // Width of a requester id; never narrower than one bit
  function automatic int id_w(input int nb_req);
    return (nb_req > 1) ? $clog2(nb_req) : 1;
  endfunction

endpackage

// File: rtl/arith_mult_cst_mersenne.sv
// Multiplier by the constant 2^CST_W-1, computed as (a << CST_W) - a.
// IN_PIPE input register stages followed by one output register; the
// side channel travels alongside the operand. Active-low synchronous reset.
module arith_mult_cst_mersenne #(
  parameter int IN_W    = 64,
  parameter int CST_W   = 64,
  parameter int IN_PIPE = 1,
  parameter int SIDE_W  = 1
) (
  input  logic                    clk,
  input  logic                    s_rst_n,
  input  logic                    in_avail,
  input  logic [IN_W-1:0]         in_a,
  input  logic [SIDE_W-1:0]       in_side,
  output logic                    out_avail,
  output logic [IN_W+CST_W-1:0]   out_z,
  output logic [SIDE_W-1:0]       out_side
);

  logic              pipe_vld;
  logic [IN_W-1:0]   pipe_a;
  logic [SIDE_W-1:0] pipe_side;

  if (IN_PIPE == 0) begin : g_no_pipe
    assign pipe_vld  = in_avail;
    assign pipe_a    = in_a;
    assign pipe_side = in_side;
  end else begin : g_pipe
    logic [IN_PIPE-1:0] vld_q;
    logic [IN_W-1:0]    a_q    [IN_PIPE];
    logic [SIDE_W-1:0]  side_q [IN_PIPE];

    // Valid shift register; cleared on reset so no stale operand survives
    always_ff @(posedge clk) begin
      if (!s_rst_n) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= in_avail;
        for (int s = 1; s < IN_PIPE; s++) vld_q[s] <= vld_q[s-1];
      end
    end

    // Operand and side payload follow the valid bits without reset
    always_ff @(posedge clk) begin
      a_q[0]    <= in_a;
      side_q[0] <= in_side;
      for (int s = 1; s < IN_PIPE; s++) begin
        a_q[s]    <= a_q[s-1];
        side_q[s] <= side_q[s-1];
      end
    end

    assign pipe_vld  = vld_q[IN_PIPE-1];
    assign pipe_a    = a_q[IN_PIPE-1];
    assign pipe_side = side_q[IN_PIPE-1];
  end

  // Output valid register
  always_ff @(posedge clk) begin
    if (!s_rst_n) out_avail <= 1'b0;
    else          out_avail <= pipe_vld;
  end

  // Shift-and-subtract product, exact over the full output width
  always_ff @(posedge clk) begin
    out_z    <= {pipe_a, {CST_W{1'b0}}} - {{CST_W{1'b0}}, pipe_a};
    out_side <= pipe_side;
  end

endmodule

// File: rtl/arith_mult_cst_mersenne_arb_rr.sv
// Round-robin grant logic. The pointer holds the last granted requester;
// the search starts just after it so every waiting requester is served
// within NB_REQ grants. Grant is combinational from req.
module arith_mult_cst_mersenne_arb_rr
  import arith_mult_cst_mersenne_arb_pkg::*;
#(
  parameter int NB_REQ = 4
) (
  input  logic                        clk,
  input  logic                        s_rst,
  input  logic                        en,
  input  logic [NB_REQ-1:0]           req,
  output logic [NB_REQ-1:0]           gnt,
  output logic [id_w(NB_REQ)-1:0]     gnt_id,
  output logic                        gnt_vld
);

  localparam int ID_W = id_w(NB_REQ);

  logic [ID_W-1:0] ptr;
  int              idx;

  // First requesting index after the pointer wins; nothing granted in reset
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NB_REQ; k++) begin
      idx = (int'(ptr) + k) % NB_REQ;
      if (!gnt_vld && en && !s_rst && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
        gnt_vld  = 1'b1;
      end
    end
  end

  // Pointer starts at the last index so requester 0 leads after reset
  always_ff @(posedge clk) begin
    if (s_rst)        ptr <= ID_W'(NB_REQ - 1);
    else if (gnt_vld) ptr <= gnt_id;
  end

endmodule

// File: rtl/common_fifo.sv
// Small synchronous FIFO with first-word-fall-through output: a word
// written at one edge is visible on rd_data right after that edge.
// Writing into a full FIFO is a caller error and is asserted against.
module common_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             s_rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             pop;

  assign rd_vld  = (count != '0);
  assign rd_data = mem[rd_ptr];
  assign pop     = rd_vld & rd_rdy;

  // Storage write; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (s_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      if (wr_en && !pop)      count <= count + CNT_W'(1);
      else if (!wr_en && pop) count <= count - CNT_W'(1);
    end
  end

  // Overflow guard
  always_ff @(posedge clk) begin
    if (!s_rst) assert (!(wr_en && count == CNT_W'(DEPTH)));
  end

endmodule

// File: rtl/arith_mult_cst_mersenne_arb.sv
// Shares one Mersenne-constant multiplier between NB_REQ requesters.
// Grants are round-robin and tagged with the requester id through the
// multiplier side channel. A credit counter sized to the output FIFO keeps
// the non-stallable multiplier from ever writing into a full FIFO.
// Optional build macro: ARITH_MULT_CST_MERSENNE_ARB_PERF_CNT_EN enables
// saturating per-requester grant counters on perf_gnt_cnt.
module arith_mult_cst_mersenne_arb
  import arith_mult_cst_mersenne_arb_pkg::*;
#(
  parameter int NB_REQ     = 4,
  parameter int IN_W       = 64,
  parameter int CST_W      = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int IN_PIPE    = 1
) (
  input  logic                         clk,
  input  logic                         s_rst,
  input  logic [NB_REQ-1:0]            in_vld,
  output logic [NB_REQ-1:0]            in_rdy,
  input  logic [NB_REQ*IN_W-1:0]       in_a,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic [IN_W+CST_W-1:0]        out_z,
  output logic [id_w(NB_REQ)-1:0]      out_id,
  output logic [NB_REQ*PERF_CNT_W-1:0] perf_gnt_cnt
);

  localparam int ID_W   = id_w(NB_REQ);
  localparam int Z_W    = IN_W + CST_W;
  localparam int CRED_W = $clog2(FIFO_DEPTH + 1);

  logic [CRED_W-1:0] credit;
  logic [NB_REQ-1:0] gnt;
  logic [ID_W-1:0]   gnt_id;
  logic              gnt_vld;
  logic              pop;
  logic [IN_W-1:0]   sel_a;
  logic              mult_avail;
  logic [Z_W-1:0]    mult_z;
  logic [ID_W-1:0]   mult_id;

  assign pop    = out_vld & out_rdy;
  assign in_rdy = gnt;

  arith_mult_cst_mersenne_arb_rr #(
    .NB_REQ (NB_REQ)
  ) u_rr (
    .clk     (clk),
    .s_rst   (s_rst),
    .en      (credit != '0),
    .req     (in_vld),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld)
  );

  // Route the granted requester's operand to the multiplier
  always_comb begin
    sel_a = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      if (gnt[i]) sel_a = in_a[i*IN_W +: IN_W];
    end
  end

  arith_mult_cst_mersenne #(
    .IN_W    (IN_W),
    .CST_W   (CST_W),
    .IN_PIPE (IN_PIPE),
    .SIDE_W  (ID_W)
  ) u_mult (
    .clk       (clk),
    .s_rst_n   (~s_rst),
    .in_avail  (gnt_vld),
    .in_a      (sel_a),
    .in_side   (gnt_id),
    .out_avail (mult_avail),
    .out_z     (mult_z),
    .out_side  (mult_id)
  );

  common_fifo #(
    .WIDTH (ID_W + Z_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .s_rst   (s_rst),
    .wr_en   (mult_avail),
    .wr_data ({mult_id, mult_z}),
    .rd_vld  (out_vld),
    .rd_rdy  (out_rdy),
    .rd_data ({out_id, out_z})
  );

  // One credit per FIFO slot: taken on grant, returned on pop
  always_ff @(posedge clk) begin
    if (s_rst)                credit <= CRED_W'(FIFO_DEPTH);
    else if (gnt_vld && !pop) credit <= credit - CRED_W'(1);
    else if (!gnt_vld && pop) credit <= credit + CRED_W'(1);
  end

  // Credits must never wrap below zero or above the FIFO depth
  always_ff @(posedge clk) begin
    if (!s_rst) begin
      assert (!(gnt_vld && !pop && credit == '0));
      assert (!(pop && !gnt_vld && credit == CRED_W'(FIFO_DEPTH)));
    end
  end

`ifdef ARITH_MULT_CST_MERSENNE_ARB_PERF_CNT_EN
  for (genvar i = 0; i < NB_REQ; i++) begin : g_perf
    logic [PERF_CNT_W-1:0] cnt;

    // Saturating count of grants to this requester
    always_ff @(posedge clk) begin
      if (s_rst)                      cnt <= '0;
      else if (gnt[i] && cnt != '1)   cnt <= cnt + PERF_CNT_W'(1);
    end

    assign perf_gnt_cnt[i*PERF_CNT_W +: PERF_CNT_W] = cnt;
  end
`else
  assign perf_gnt_cnt = '0;
`endif

endmodule
